// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares one single-ported memory between the instruction-fetch port and the
//   load/store port. Data wins arbitration unless fetch has waited through
//   MAX_STREAK back-to-back data grants. A transaction that sees no mem_ack for
//   TIMEOUT busy cycles is aborted and reported through bus_err.
//
// Ports
//   clk, reset            : clock, synchronous active-high reset
//   if_req/if_addr        : fetch request and address (held until if_ack)
//   if_ack/if_rdata       : fetch completion pulse and instruction word
//   d_req/d_we/d_addr/
//   d_wdata/d_size        : data request (held until d_ack)
//   d_ack/d_rdata         : data completion pulse and load data
//   mem_req/mem_we/mem_addr/
//   mem_wdata/mem_size    : memory-side request, held until mem_ack or abort
//   mem_ack/mem_rdata     : memory completion, read data valid with ack
//   stall_fetch/stall_mem : per-port stall for the control unit
//   bus_err               : pulses with the ack of an aborted transaction
module mem_arbiter #(
  parameter int MAX_STREAK = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ack,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [2:0]  d_size,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [2:0]  mem_size,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        stall_fetch,
  output logic        stall_mem,
  output logic        bus_err
);

  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_D} state_t;

  localparam int              TW         = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0]   TCNT_LAST  = TW'(TIMEOUT - 1);
  localparam logic [2:0]      STREAK_LIM = 3'(MAX_STREAK);
  localparam logic [31:0]     NOP_INSN   = 32'h0000_0013;

  state_t        state_q, state_d;
  logic          mem_req_q, mem_req_d;
  logic          mem_we_q, mem_we_d;
  logic [31:0]   mem_addr_q, mem_addr_d;
  logic [31:0]   mem_wdata_q, mem_wdata_d;
  logic [2:0]    mem_size_q, mem_size_d;
  logic          if_ack_q, if_ack_d;
  logic          d_ack_q, d_ack_d;
  logic          bus_err_q, bus_err_d;
  logic [31:0]   if_rdata_q, if_rdata_d;
  logic [31:0]   d_rdata_q, d_rdata_d;
  logic [2:0]    streak_q, streak_d;
  logic [TW-1:0] tcnt_q, tcnt_d;

  logic          if_elig, d_elig;
  logic          grant_if, grant_d;
  logic          finish;
  logic [31:0]   rdata_sel;

  // A port acked this cycle still holds its request; masking it stops the
  // same request from being granted twice.
  assign if_elig = if_req & ~if_ack_q;
  assign d_elig  = d_req & ~d_ack_q;

  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_size_d  = mem_size_q;
    if_ack_d    = 1'b0;
    d_ack_d     = 1'b0;
    bus_err_d   = 1'b0;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    streak_d    = streak_q;
    tcnt_d      = tcnt_q;
    grant_if    = 1'b0;
    grant_d     = 1'b0;
    finish      = 1'b0;
    rdata_sel   = 32'h0;

    case (state_q)
      IDLE: begin
        if (d_elig && (!if_elig || (streak_q < STREAK_LIM))) begin
          grant_d = 1'b1;
        end else if (if_elig) begin
          grant_if = 1'b1;
        end

        if (grant_d) begin
          state_d     = BUSY_D;
          mem_req_d   = 1'b1;
          mem_we_d    = d_we;
          mem_addr_d  = d_addr;
          mem_wdata_d = d_wdata;
          mem_size_d  = d_size;
          tcnt_d      = '0;
        end else if (grant_if) begin
          state_d     = BUSY_IF;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = if_addr;
          mem_wdata_d = 32'h0;
          mem_size_d  = 3'b010;
          tcnt_d      = '0;
        end

        // Streak only measures data grants taken while fetch is waiting.
        if (!if_req || grant_if) begin
          streak_d = 3'd0;
        end else if (grant_d && (streak_q != 3'd7)) begin
          streak_d = streak_q + 3'd1;
        end
      end

      BUSY_IF, BUSY_D: begin
        // An ack in the expiry cycle still counts as a normal completion.
        if (mem_ack) begin
          finish    = 1'b1;
          rdata_sel = mem_rdata;
        end else if (tcnt_q == TCNT_LAST) begin
          finish    = 1'b1;
          bus_err_d = 1'b1;
          rdata_sel = (state_q == BUSY_IF) ? NOP_INSN : 32'h0;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end

        if (finish) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
          tcnt_d    = '0;
          if (state_q == BUSY_IF) begin
            if_ack_d   = 1'b1;
            if_rdata_d = rdata_sel;
          end else begin
            d_ack_d   = 1'b1;
            d_rdata_d = rdata_sel;
          end
        end
      end

      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'h0;
      mem_wdata_q <= 32'h0;
      mem_size_q  <= 3'b000;
      if_ack_q    <= 1'b0;
      d_ack_q     <= 1'b0;
      bus_err_q   <= 1'b0;
      if_rdata_q  <= 32'h0;
      d_rdata_q   <= 32'h0;
      streak_q    <= 3'd0;
      tcnt_q      <= '0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_size_q  <= mem_size_d;
      if_ack_q    <= if_ack_d;
      d_ack_q     <= d_ack_d;
      bus_err_q   <= bus_err_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
      streak_q    <= streak_d;
      tcnt_q      <= tcnt_d;
    end
  end

  assign mem_req     = mem_req_q;
  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign mem_size    = mem_size_q;
  assign if_ack      = if_ack_q;
  assign d_ack       = d_ack_q;
  assign bus_err     = bus_err_q;
  assign if_rdata    = if_rdata_q;
  assign d_rdata     = d_rdata_q;
  assign stall_fetch = if_req & ~if_ack_q;
  assign stall_mem   = d_req & ~d_ack_q;

endmodule
